// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequential 4:1 mux channel scanner with start/done handshake; continuous scan under MUX_SCAN_CONT_EN
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_out,
`ifdef MUX_SCAN_CONT_EN
  input  logic       cont,
`endif
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_DONE} state_t;
  localparam logic [3:0] LOAD = SETTLE[3:0];
  localparam state_t FIRST = SETTLE == 0 ? ST_CAPTURE : ST_SETTLE;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, work, work_n, mask_q, mask_n, sample_n, hi, lm;
  logic [1:0] sel, sel_n;
  logic cont_go;
`ifdef MUX_SCAN_CONT_EN
  assign cont_go = cont;
`else
  assign cont_go = 1'b0;
`endif
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
  endfunction
  assign hi = mask_q & (4'b1110 << sel);
  assign lm = state == ST_IDLE ? mask : mask_q;
  assign {s1, s0} = sel;
  assign busy = state == ST_SETTLE || state == ST_CAPTURE;
  assign done = state == ST_DONE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = sel;
    work_n = work;
    mask_n = mask_q;
    sample_n = sample;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_n = ST_IDLE;
        if (state == ST_IDLE ? start : cont_go) begin
          mask_n = lm;
          work_n = '0;
          sel_n = lowest(lm);
          cnt_n = LOAD;
          state_n = |lm ? FIRST : ST_DONE;
          sample_n = |lm ? sample : 4'b0000;
        end
      end
      ST_SETTLE: begin
        cnt_n = cnt - 4'd1;
        state_n = cnt <= 4'd1 ? ST_CAPTURE : ST_SETTLE;
      end
      ST_CAPTURE: begin
        work_n[sel] = mux_out;
        sel_n = |hi ? lowest(hi) : 2'd0;
        cnt_n = LOAD;
        state_n = |hi ? FIRST : ST_DONE;
        sample_n = |hi ? sample : work_n;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      sel <= '0;
      work <= '0;
      mask_q <= '0;
      sample <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sel <= sel_n;
      work <= work_n;
      mask_q <= mask_n;
      sample <= sample_n;
    end
  end
endmodule
